// File: rtl/cvt_pkg.sv
// Shared types and helpers for the integer-to-float conversion unit.
package cvt_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RDN = 2'd2,
        RM_RUP = 2'd3
    } rm_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic int bias(input int nexp);
        return (1 << (nexp - 1)) - 1;
    endfunction

endpackage

// File: rtl/cvt_round.sv
// Rounding-increment decision from lsb/guard/sticky; shared with fp narrowing converters.
// CVT_DIRECTED_ROUND_EN enables RTZ/RDN/RUP; otherwise RNE is always applied.
module cvt_round
    import cvt_pkg::*;
(
    input  logic       sign_i,
    input  logic [1:0] rm_i,
    input  logic       lsb_i,
    input  logic       guard_i,
    input  logic       sticky_i,
    output logic       increment_o,
    output logic       inexact_o
);

    always_comb begin
        increment_o = guard_i & (sticky_i | lsb_i);
`ifdef CVT_DIRECTED_ROUND_EN
        case (rm_e'(rm_i))
            RM_RTZ:  increment_o = 1'b0;
            RM_RDN:  increment_o = sign_i & (guard_i | sticky_i);
            RM_RUP:  increment_o = ~sign_i & (guard_i | sticky_i);
            default: increment_o = guard_i & (sticky_i | lsb_i);
        endcase
`endif
    end

    assign inexact_o = guard_i | sticky_i;

`ifndef CVT_DIRECTED_ROUND_EN
    // Sign and mode only matter for directed rounding.
    logic unused_rm;
    assign unused_rm = ^{sign_i, rm_i};
`endif

endmodule

// File: rtl/cvt_int2fp_seq.sv
// Multi-cycle signed/unsigned integer to IEEE-754 converter with valid/ready handshake.
// Optional macro CVT_DIRECTED_ROUND_EN enables the directed rounding modes.
module cvt_int2fp_seq
    import cvt_pkg::*;
#(
    parameter int INTn = 64,
    parameter int NEXP = 11,
    parameter int NSIG = 52
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INTn-1:0]          in_data,
    input  logic                     in_signed,
    input  logic [1:0]               in_rm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NEXP+NSIG:0]       out_data,
    output logic                     out_inexact
);

    localparam int K       = $clog2(INTn);
    localparam int W       = NEXP + NSIG + 1;
    localparam int BIAS    = bias(NEXP);
    localparam int EXP_TOP = (INTn - 1) + BIAS;
    localparam int EW      = INTn + NSIG + 1;

    if ((INTn & (INTn - 1)) != 0 || INTn < 8 || INTn > 128) begin : g_bad_intn
        $error("cvt_int2fp_seq: INTn must be a power of two in 8..128");
    end
    if (EXP_TOP >= (1 << NEXP) - 1) begin : g_bad_exp
        $error("cvt_int2fp_seq: exponent range too small for INTn");
    end

    state_e            state_q;
    logic [INTn-1:0]   mag_q;
    logic              sign_q;
    logic [1:0]        rm_q;
    logic [K-1:0]      shift_q;
    logic [K-1:0]      step_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [W-1:0]      out_data_q;
    logic              out_inexact_q;

    // Normalisation: test whether the top `step` bits are all zero.
    logic [INTn-1:0] top_mask;
    logic            top_zero;
    assign top_mask = ~({INTn{1'b1}} >> step_q);
    assign top_zero = ((mag_q & top_mask) == '0);

    // Bits below the leading one, zero-padded so narrow integers need no special case.
    logic [EW-1:0]   ext;
    logic [NSIG-1:0] frac;
    logic            guard;
    logic            sticky;
    logic            incr;
    logic            inexact;
    assign ext    = {mag_q[INTn-2:0], {(NSIG + 2){1'b0}}};
    assign frac   = ext[EW-1 -: NSIG];
    assign guard  = ext[EW-1-NSIG];
    assign sticky = |ext[EW-2-NSIG:0];

    cvt_round u_round (
        .sign_i      (sign_q),
        .rm_i        (rm_q),
        .lsb_i       (frac[0]),
        .guard_i     (guard),
        .sticky_i    (sticky),
        .increment_o (incr),
        .inexact_o   (inexact)
    );

    logic [NSIG:0]   frac_sum;
    logic [NEXP-1:0] exp_val;
    logic            is_zero;
    logic [W-1:0]    out_data_d;
    logic            out_inexact_d;
    assign frac_sum      = {1'b0, frac} + {{NSIG{1'b0}}, incr};
    assign exp_val       = NEXP'(EXP_TOP) - NEXP'(shift_q) + {{(NEXP-1){1'b0}}, frac_sum[NSIG]};
    assign is_zero       = ~mag_q[INTn-1];
    assign out_data_d    = is_zero ? '0 : {sign_q, exp_val, frac_sum[NSIG-1:0]};
    assign out_inexact_d = is_zero ? 1'b0 : inexact;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mag_q         <= '0;
            sign_q        <= 1'b0;
            rm_q          <= 2'd0;
            shift_q       <= '0;
            step_q        <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q     <= in_signed & in_data[INTn-1];
                        mag_q      <= (in_signed & in_data[INTn-1]) ? -in_data : in_data;
                        rm_q       <= in_rm;
                        shift_q    <= '0;
                        step_q     <= K'(INTn / 2);
                        in_ready_q <= 1'b0;
                        state_q    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (top_zero) begin
                        mag_q   <= mag_q << step_q;
                        shift_q <= shift_q | step_q;
                    end
                    step_q <= step_q >> 1;
                    if (step_q == K'(1)) begin
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    out_data_q    <= out_data_d;
                    out_inexact_q <= out_inexact_d;
                    out_valid_q   <= 1'b1;
                    state_q       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_inexact = out_inexact_q;

endmodule
